bcd_to_bin_seq: RTL and testbench

Sequential BCD-to-binary converter using the reverse double-dabble algorithm (shift right, then subtract 3 from any digit ≥ 8), one bit per clock. It is the inverse of the team's binary-to-BCD display path. It converts switch- or keypad-entered decimal digits back to a binary value for arithmetic. It takes one packed BCD word on a start strobe and returns the binary result with a one-cycle done pulse.

---
 rtl/bcd_pkg.sv | 20 ++
 rtl/bcd_to_bin_seq_if.sv | 38 +++
 rtl/bcd_digit_sub3.sv | 20 ++
 rtl/bcd_to_bin_seq.sv | 132 +++++++++++++
 tb/tb_bcd_to_bin_seq.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/bcd_pkg.sv
// bcd_pkg: constants and types shared by the BCD conversion paths
// (BCD-to-binary and binary-to-BCD).
//   DIGIT_W       width of one BCD digit
//   CORR_THRESH   digit value at or above which a correction is applied
//   CORR_OFFSET   correction amount subtracted from a digit
//   BCD_MAX_DIGIT largest legal BCD digit
//   state_t       converter control states
package bcd_pkg;

    localparam int unsigned DIGIT_W       = 4;
    localparam logic [3:0]  CORR_THRESH   = 4'd8;
    localparam logic [3:0]  CORR_OFFSET   = 4'd3;
    localparam logic [3:0]  BCD_MAX_DIGIT = 4'd9;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

endpackage

// File: rtl/bcd_to_bin_seq_if.sv
// bcd_to_bin_seq_if: request/result bundle for the BCD-to-binary converter.
//   start   request strobe (master -> slave)
//   bcd_in  packed BCD word, digit 0 in [3:0] (master -> slave)
//   busy    conversion in progress (slave -> master)
//   done    one-cycle result-valid pulse (slave -> master)
//   bin_out binary result, held until the next done (slave -> master)
//   err     invalid-digit flag, valid with done (slave -> master)
interface bcd_to_bin_seq_if #(
    parameter int unsigned DIGITS = 3,
    parameter int unsigned BIN_W  = 10
);

    logic                  start;
    logic [4*DIGITS-1:0]   bcd_in;
    logic                  busy;
    logic                  done;
    logic [BIN_W-1:0]      bin_out;
    logic                  err;

    modport master (
        output start,
        output bcd_in,
        input  busy,
        input  done,
        input  bin_out,
        input  err
    );

    modport slave (
        input  start,
        input  bcd_in,
        output busy,
        output done,
        output bin_out,
        output err
    );

endinterface

// File: rtl/bcd_digit_sub3.sv
// bcd_digit_sub3: combinational digit correction cell for reverse
// double-dabble. Subtracts the offset from digits at or above the threshold.
//   digit_i  4-bit digit after the shift
//   digit_o  corrected digit
module bcd_digit_sub3
    import bcd_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    // A digit >= 8 minus 3 never underflows.
    always_comb begin
        digit_o = digit_i;
        if (digit_i >= CORR_THRESH) begin
            digit_o = digit_i - CORR_OFFSET;
        end
    end

endmodule

// File: rtl/bcd_to_bin_seq.sv
// bcd_to_bin_seq: sequential BCD-to-binary converter, one bit per clock,
// using reverse double-dabble (shift right, then correct each digit >= 8).
// Optional macro BCD2BIN_CHECK_EN: flag inputs containing a digit > 9;
// such a conversion returns bin_out=0 with err=1.
//   clk    clock, rising edge
//   rst_n  synchronous active-low reset
//   bus    bcd_to_bin_seq_if slave: start, bcd_in, busy, done, bin_out, err
module bcd_to_bin_seq
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = 3,
    parameter int unsigned BIN_W  = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    bcd_to_bin_seq_if.slave bus
);

    localparam int unsigned BCD_W = DIGITS * DIGIT_W;
    localparam int unsigned W_W   = BCD_W + BIN_W;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);

    state_t             state_q, state_d;
    logic [W_W-1:0]     w_q, w_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic               done_q, done_d;

    logic [W_W-1:0]     w_shr;
    logic [BCD_W-1:0]   bcd_corr;
    logic [W_W-1:0]     w_step;

    assign w_shr = w_q >> 1;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit_sub3 u_sub3 (
            .digit_i (w_shr[BIN_W + g*DIGIT_W +: DIGIT_W]),
            .digit_o (bcd_corr[g*DIGIT_W +: DIGIT_W])
        );
    end

    assign w_step = {bcd_corr, w_shr[BIN_W-1:0]};

`ifdef BCD2BIN_CHECK_EN
    logic inv_q, inv_d;
    logic err_q, err_d;
    logic in_invalid;

    always_comb begin
        in_invalid = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (bus.bcd_in[i*DIGIT_W +: DIGIT_W] > BCD_MAX_DIGIT) begin
                in_invalid = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        cnt_d   = cnt_q;
        bin_d   = bin_q;
        done_d  = 1'b0;
`ifdef BCD2BIN_CHECK_EN
        inv_d   = inv_q;
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    w_d     = {bus.bcd_in, {BIN_W{1'b0}}};
                    cnt_d   = '0;
                    state_d = SHIFT;
`ifdef BCD2BIN_CHECK_EN
                    inv_d   = in_invalid;
`endif
                end
            end
            SHIFT: begin
                w_d   = w_step;
                cnt_d = cnt_q + 1'b1;
                // cnt_q counts completed shifts, so BIN_W-1 marks the last one.
                if (cnt_q == CNT_W'(BIN_W - 1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
`ifdef BCD2BIN_CHECK_EN
                    bin_d   = inv_q ? '0 : w_step[BIN_W-1:0];
                    err_d   = inv_q;
`else
                    bin_d   = w_step[BIN_W-1:0];
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            w_q     <= '0;
            cnt_q   <= '0;
            bin_q   <= '0;
            done_q  <= 1'b0;
`ifdef BCD2BIN_CHECK_EN
            inv_q   <= 1'b0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            done_q  <= done_d;
`ifdef BCD2BIN_CHECK_EN
            inv_q   <= inv_d;
            err_q   <= err_d;
`endif
        end
    end

    assign bus.busy    = (state_q == SHIFT);
    assign bus.done    = done_q;
    assign bus.bin_out = bin_q;
`ifdef BCD2BIN_CHECK_EN
    assign bus.err     = err_q;
`else
    assign bus.err     = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// tb_bcd_to_bin_seq: directed self-checking bench for bcd_to_bin_seq.
// Define BCD2BIN_CHECK_EN to also exercise invalid-digit flagging.
module tb_bcd_to_bin_seq;

    logic clk;
    logic rst_n;
    int   total;
    int   passed;

    bcd_to_bin_seq_if #(.DIGITS(3), .BIN_W(10)) bus ();

    bcd_to_bin_seq #(.DIGITS(3), .BIN_W(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Advance one edge; inputs and samples both move 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one edge, then wait for done. Latency counts edges
    // from the first edge that sees start: 11 for the defaults.
    task automatic convert(input logic [11:0] bcd, input logic [9:0] exp_bin,
                           input logic exp_err, input string tag);
        int n, busy_n;
        bit got;
        n = 0; busy_n = 0; got = 0;
        bus.bcd_in = bcd;
        bus.start  = 1'b1;
        while (!got && n < 30) begin
            step();
            n++;
            bus.start  = 1'b0;
            bus.bcd_in = 12'hFFF;   // later input changes must not matter
            if (bus.busy) busy_n++;
            if (bus.done) got = 1;
        end
        check({tag, "_done_seen"}, 32'(got), 32'd1);
        check({tag, "_latency"}, 32'(n), 32'd11);
        check({tag, "_busy_cycles"}, 32'(busy_n), 32'd10);
        check({tag, "_bin"}, 32'(bus.bin_out), 32'(exp_bin));
        check({tag, "_err"}, 32'(bus.err), 32'(exp_err));
        step();
        check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        int n, dones, first_at, second_at;
        logic [9:0] first_val, second_val;

        total = 0; passed = 0;
        rst_n = 1'b0;
        bus.start  = 1'b0;
        bus.bcd_in = '0;
        step(); step();
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_bin", 32'(bus.bin_out), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        rst_n = 1'b1;
        step();

        convert(12'h255, 10'd255, 1'b0, "c255");
        convert(12'h999, 10'd999, 1'b0, "c999");
        convert(12'h000, 10'd0, 1'b0, "c000");
        convert(12'h501, 10'd501, 1'b0, "c501");

        // Second start 4 edges into a conversion is ignored.
        dones = 0; first_at = 0;
        bus.bcd_in = 12'h123;
        bus.start  = 1'b1;
        for (int i = 1; i <= 25; i++) begin
            step();
            bus.start = 1'b0;
            if (i == 4) begin
                bus.start  = 1'b1;
                bus.bcd_in = 12'h456;
            end
            if (bus.done) begin
                dones++;
                if (dones == 1) begin
                    first_at  = i;
                    first_val = bus.bin_out;
                end
            end
        end
        check("ign_done_count", 32'(dones), 32'd1);
        check("ign_latency", 32'(first_at), 32'd11);
        check("ign_bin", 32'(first_val), 32'd123);

        // Reset for one edge mid-conversion aborts it.
        dones = 0;
        bus.bcd_in = 12'h777;
        bus.start  = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step();
            bus.start = 1'b0;
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_bin", 32'(bus.bin_out), 32'd0);
        for (int i = 0; i < 15; i++) begin
            if (bus.done) dones++;
            step();
        end
        check("abort_no_done", 32'(dones), 32'd0);
        convert(12'h042, 10'd42, 1'b0, "c042");

        // start held across done: back-to-back conversions.
        dones = 0; first_at = 0; second_at = 0;
        first_val = '0; second_val = '0;
        bus.bcd_in = 12'h100;
        bus.start  = 1'b1;
        n = 0;
        while (n < 40) begin
            step();
            n++;
            if (n == 1) bus.bcd_in = 12'h007;
            if (dones == 1 && n == first_at + 1) bus.start = 1'b0;
            if (bus.done) begin
                dones++;
                if (dones == 1) begin
                    first_at  = n;
                    first_val = bus.bin_out;
                end else if (dones == 2) begin
                    second_at  = n;
                    second_val = bus.bin_out;
                end
            end
        end
        check("b2b_done_count", 32'(dones), 32'd2);
        check("b2b_first_at", 32'(first_at), 32'd11);
        check("b2b_first_bin", 32'(first_val), 32'd100);
        check("b2b_gap", 32'(second_at - first_at), 32'd11);
        check("b2b_second_bin", 32'(second_val), 32'd7);

`ifdef BCD2BIN_CHECK_EN
        convert(12'h0A3, 10'd0, 1'b1, "inv0A3");
        convert(12'h123, 10'd123, 1'b0, "after_inv");
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
